// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 16:1 single-bit mux through all channels, samples
// each channel after a programmable settle time, and hands the assembled
// 16-bit word downstream over a valid/ready handshake.
module mux_scan_ctrl #(
    parameter int SETTLE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cont,
    input  logic        y_in,
    input  logic        ready,
    output logic [3:0]  sel,
    output logic [15:0] data,
    output logic        valid,
    output logic        busy,
    output logic [7:0]  scan_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Settle target narrowed to the counter width; legal range is 0..15.
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  sel_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic [15:0] shadow_r;
    logic [15:0] shadow_s;
    logic [15:0] data_s;
    logic        valid_s;
    logic        busy_s;
    logic [7:0]  count_s;

    // Next-state and next-output logic; every register holds unless a branch updates it.
    always_comb begin
        state_s  = state_r;
        sel_s    = sel;
        cnt_s    = cnt_r;
        shadow_s = shadow_r;
        data_s   = data;
        valid_s  = valid;
        count_s  = scan_count;

        case (state_r)
            IDLE: begin
                if (start) begin
                    sel_s    = 4'd0;
                    cnt_s    = 4'd0;
                    shadow_s = 16'd0;
                    state_s  = WAIT;
                end else begin
                    state_s  = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r != SETTLE_C) begin
                    cnt_s = cnt_r + 4'd1;
                end else begin
                    // Sampling edge: y_in is only looked at here, so settle-time glitches are ignored.
                    shadow_s[sel] = y_in;
                    if (sel == 4'd15) begin
                        // The last channel bypasses the shadow so the word is complete on this edge.
                        data_s  = {y_in, shadow_r[14:0]};
                        valid_s = 1'b1;
                        state_s = DONE;
                    end else begin
                        sel_s = sel + 4'd1;
                        cnt_s = 4'd0;
                    end
                end
            end
            DONE: begin
                if (valid && ready) begin
                    valid_s = 1'b0;
                    count_s = scan_count + 8'd1;
                    sel_s   = 4'd0;
                    if (cont) begin
                        // Back-to-back scan with no idle cycle in between.
                        cnt_s    = 4'd0;
                        shadow_s = 16'd0;
                        state_s  = WAIT;
                    end else begin
                        state_s  = IDLE;
                    end
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                sel_s   = 4'd0;
                cnt_s   = 4'd0;
                valid_s = 1'b0;
            end
        endcase

        busy_s = (state_s == WAIT) || (state_s == DONE);
    end

    // State and output registers with asynchronous reset to the idle, empty condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            sel        <= 4'd0;
            cnt_r      <= 4'd0;
            shadow_r   <= 16'd0;
            data       <= 16'd0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            scan_count <= 8'd0;
        end else begin
            state_r    <= state_s;
            sel        <= sel_s;
            cnt_r      <= cnt_s;
            shadow_r   <= shadow_s;
            data       <= data_s;
            valid      <= valid_s;
            busy       <= busy_s;
            scan_count <= count_s;
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl: two instances (settle 0 and settle 2) driven by
// mux models; expected words go into per-instance queues and a monitor
// compares them on every handshake.
module tb_mux_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start0 = 1'b0, cont0 = 1'b0, ready0 = 1'b1;
    logic [15:0] p0 = 16'd0;
    logic        y0;
    logic [3:0]  sel0;
    logic [15:0] data0;
    logic        valid0, busy0;
    logic [7:0]  count0;

    logic        start2 = 1'b0, cont2 = 1'b0, ready2 = 1'b1;
    logic [15:0] p2 = 16'd0;
    logic        glitch2 = 1'b0;
    logic        y2;
    logic [3:0]  sel2;
    logic [15:0] data2;
    logic        valid2, busy2;
    logic [7:0]  count2;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] q0[$];
    logic [15:0] q2[$];
    logic [7:0]  exp_count0 = 8'd0;

    // Mux models: output is the pattern bit selected by sel, optionally inverted.
    assign y0 = p0[sel0];
    assign y2 = p2[sel2] ^ glitch2;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.SETTLE(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .cont(cont0), .y_in(y0),
        .ready(ready0), .sel(sel0), .data(data0), .valid(valid0),
        .busy(busy0), .scan_count(count0)
    );

    mux_scan_ctrl #(.SETTLE(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .cont(cont2), .y_in(y2),
        .ready(ready2), .sel(sel2), .data(data2), .valid(valid2),
        .busy(busy2), .scan_count(count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each handshake on either instance pops one expected word.
    always @(negedge clk) begin
        if (!rst && valid0 && ready0) begin
            if (q0.size() == 0) begin
                total_cnt++;
                $display("FAIL sb0_unexpected: got word %0h, expected none", data0);
            end else begin
                check("sb0_data", data0, q0.pop_front());
            end
        end
        if (!rst && valid2 && ready2) begin
            if (q2.size() == 0) begin
                total_cnt++;
                $display("FAIL sb2_unexpected: got word %0h, expected none", data2);
            end else begin
                check("sb2_data", data2, q2.pop_front());
            end
        end
    end

    task automatic pulse_start0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    task automatic wait_valid0(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid0 && n < budget);
        check("valid0_timeout", valid0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev;
        logic       saw_wrap;

        // Reset state
        #1;
        check("rst_sel0", sel0, 0);
        check("rst_data0", data0, 0);
        check("rst_valid0", valid0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_count0", count0, 0);
        check("rst_valid2", valid2, 0);
        check("rst_data2", data2, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Basic scan, settle 0
        p0 = 16'h5441; ready0 = 1'b1; cont0 = 1'b0;
        q0.push_back(16'h5441);
        pulse_start0();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("basic_sel", sel0, k);
            check("basic_valid_low", valid0, 0);
            check("basic_busy", busy0, 1);
            @(posedge clk);
        end
        @(negedge clk);
        check("basic_valid_e16", valid0, 1);
        @(posedge clk); #1;
        exp_count0 = exp_count0 + 8'd1;
        check("basic_count", count0, exp_count0);
        check("basic_busy_after", busy0, 0);
        check("basic_valid_after", valid0, 0);

        // Settle timing on the settle-2 instance, channel 5 glitched while settling
        p2 = 16'hA5C3; ready2 = 1'b1;
        q2.push_back(16'hA5C3);
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            @(posedge clk); #1;
            if (k == 15) glitch2 = 1'b1;
            if (k == 17) glitch2 = 1'b0;
            check("settle_valid", valid2, (k == 48) ? 1 : 0);
        end
        @(posedge clk); #1;
        check("settle_valid_after", valid2, 0);
        check("settle_busy_after", busy2, 0);
        check("settle_count", count2, 1);

        // Backpressure: ready low for 10 cycles, start pulsed during DONE
        p0 = 16'h3C96; ready0 = 1'b0;
        q0.push_back(16'h3C96);
        pulse_start0();
        wait_valid0(40);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) start0 = 1'b1;
            if (i == 4) start0 = 1'b0;
            @(negedge clk);
            check("bp_valid", valid0, 1);
            check("bp_data", data0, 16'h3C96);
            check("bp_sel", sel0, 15);
            check("bp_busy", busy0, 1);
        end
        @(posedge clk); #1 ready0 = 1'b1;
        @(posedge clk); #1;
        exp_count0 = exp_count0 + 8'd1;
        check("bp_valid_after", valid0, 0);
        check("bp_busy_after", busy0, 0);
        check("bp_count", count0, exp_count0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_restart", busy0, 0);

        // Continuous mode: two words 16 cycles apart, busy held high
        p0 = 16'h0001; cont0 = 1'b1; ready0 = 1'b1;
        q0.push_back(16'h0001);
        q0.push_back(16'h8000);
        pulse_start0();
        wait_valid0(40);
        @(posedge clk); #1;
        p0 = 16'h8000; cont0 = 1'b0;
        exp_count0 = exp_count0 + 8'd1;
        check("cont_count1", count0, exp_count0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("cont_gap_valid", valid0, 0);
            check("cont_busy", busy0, 1);
            @(posedge clk);
        end
        @(negedge clk);
        check("cont_valid_h16", valid0, 1);
        @(posedge clk); #1;
        exp_count0 = exp_count0 + 8'd1;
        check("cont_count2", count0, exp_count0);
        check("cont_busy_end", busy0, 0);

        // Reset mid-scan at channel 7
        p0 = 16'hFFFF;
        pulse_start0();
        repeat (7) @(posedge clk);
        #1;
        check("mid_sel7", sel0, 7);
        rst = 1'b1;
        #1;
        check("mid_rst_sel", sel0, 0);
        check("mid_rst_valid", valid0, 0);
        check("mid_rst_data", data0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_count", count0, 0);
        exp_count0 = 8'd0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_no_autostart", busy0, 0);
        check("mid_data_held0", data0, 0);
        p0 = 16'h6A19;
        q0.push_back(16'h6A19);
        pulse_start0();
        wait_valid0(40);
        @(posedge clk); #1;
        exp_count0 = exp_count0 + 8'd1;
        check("mid_count", count0, exp_count0);

        // Count wrap: 256 back-to-back handshaked scans
        p0 = 16'hBEEF; cont0 = 1'b1; ready0 = 1'b1;
        for (int i = 0; i < 256; i++) q0.push_back(16'hBEEF);
        prev = count0;
        saw_wrap = 1'b0;
        pulse_start0();
        for (int i = 0; i < 256; i++) begin
            wait_valid0(40);
            if (i == 255) cont0 = 1'b0;
            @(posedge clk); #1;
            exp_count0 = exp_count0 + 8'd1;
            check("wrap_count", count0, exp_count0);
            if (prev == 8'd255 && count0 == 8'd0) saw_wrap = 1'b1;
            prev = count0;
        end
        check("wrap_seen_255_to_0", saw_wrap, 1);
        check("wrap_busy_end", busy0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("sb0_drained", q0.size(), 0);
        check("sb2_drained", q2.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencing controller for the 16:1 single-bit channel mux. It drives the mux's 4-bit select and samples the mux's 1-bit output once per channel after a programmable settle time. It assembles the 16 samples into one word and hands that word downstream with a valid/ready handshake. It sits directly around the mux: `sel` feeds the mux select input, and the mux output returns on `y_in`.

## Interface
- `SETTLE`, default 0: extra wait cycles per channel between a `sel` change and the sampling edge; legal range 0–15.
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin one scan; sampled only in IDLE.
- `cont`  in  1  continuous mode; sampled at the output handshake edge.
- `y_in`  in  1  mux output.
- `ready`  in  1  downstream accepts `data`.
- `sel`  out  4  registered mux select.
- `data`  out  16  assembled word; bit k = `y_in` sampled while `sel`==k.
- `valid`  out  1  `data` holds a complete scan.
- `busy`  out  1  high in WAIT and DONE.
- `scan_count`  out  8  completed (handshaked) scans, wraps modulo 256.

## Operation
- States: IDLE, WAIT, DONE. Internal settle counter `cnt` is 4 bits; internal shadow word is 16 bits.
- Reset (async, immediate): state=IDLE, `sel`=0, `cnt`=0, shadow=0, `data`=0, `valid`=0, `busy`=0, `scan_count`=0.
- IDLE:
  - `start`=1 at an edge: `sel`←0, `cnt`←0, shadow←0, go to WAIT.
  - `start`=0: remain in IDLE, all outputs hold.
- WAIT, `cnt`≠`SETTLE`: `cnt`←`cnt`+1.
- WAIT, `cnt`==`SETTLE`:
  - Sample: shadow[`sel`]←`y_in`.
  - If `sel`==15: `data`←shadow with bit 15 = `y_in`, `valid`←1, go to DONE. `sel` holds at 15.
  - Otherwise: `sel`←`sel`+1, `cnt`←0.
- DONE: `data` and `valid` hold while `ready`=0. At the edge where `valid`=1 and `ready`=1:
  - `valid`←0 and `scan_count`←`scan_count`+1 (255→0).
  - `cont`=1: `sel`←0, `cnt`←0, shadow←0, go to WAIT. No idle cycle.
  - `cont`=0: `sel`←0, go to IDLE.
- `start` is ignored outside IDLE and never aborts or restarts a scan.
- `y_in` is don't-care on every edge that is not a sampling edge; glitches during settle cycles must not affect `data`.
- `data` changes only on the transition into DONE and on reset. It keeps its last value in IDLE and during the next scan.

## Timing
- Edge E0 is the edge that accepts `start`. `sel`=k is driven from E0 + k·(`SETTLE`+1) onward.
- Channel k is sampled at edge E0 + (k+1)·(`SETTLE`+1).
- `valid` rises after edge E0 + 16·(`SETTLE`+1): 16 cycles for `SETTLE`=0, 48 cycles for `SETTLE`=2.
- Back-to-back mode: the next `valid` rises 16·(`SETTLE`+1) edges after the handshake edge.
- `busy` is registered with state: high from E0+ through the handshake edge, low after it if `cont`=0.
- Reset mid-scan: all outputs return to their reset values asynchronously. A scan needs a fresh `start` after `rst` deasserts. No partial word ever appears on `data`.

## Test plan
- Basic scan: `SETTLE`=0; bench mux model drives `y_in`=P[`sel`] with P=16'h5441; pulse `start`, hold `ready`=1. Required: `sel` steps 0..15 one per cycle; `valid` high 16 cycles after E0 with `data`=16'h5441; `scan_count`=1; `busy` low afterwards.
- Settle timing: `SETTLE`=2, P=16'hA5C3. Force `y_in` to the inverse value during non-sampling cycles of channel 5. Required: `data`=16'hA5C3 and `valid` at E0+48.
- Backpressure: `ready`=0 for 10 cycles after `valid`, with `start` pulsed during DONE. Required:
  - `data` and `valid` are stable for those 10 cycles.
  - No restart occurs.
  - `ready`=1 completes the handshake: `valid`=0, state returns to IDLE, `scan_count` increments once.
- Continuous mode: `cont`=1, `ready`=1. P changes 16'h0001→16'h8000 between scans. Required: consecutive words 16'h0001 then 16'h8000, spaced 16 cycles apart; `busy` stays high throughout.
- Reset mid-scan: assert `rst` while `sel`=7. Required: immediate `sel`=0, `valid`=0, `data`=0, `busy`=0. A later `start` gives a correct full word.
- Count wrap: run 256 handshaked scans. Required: `scan_count` reads 255 and then 0.
